// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared definitions for the divide program ISA. Both the instruction memory
// and the program executor import this package.
//   DW      : data width of immediates and arithmetic registers
//   PCW     : program counter / selector width
//   LAST_PC : highest valid program address
//   OP_*    : 3-bit opcodes
//   state_t : executor FSM state encoding
// -----------------------------------------------------------------------------
package isa_pkg;

  localparam int DW      = 4;
  localparam int PCW     = 3;
  localparam int LAST_PC = 6;

  localparam logic [2:0] OP_CLR = 3'b000;
  localparam logic [2:0] OP_LD1 = 3'b001;
  localparam logic [2:0] OP_LD2 = 3'b010;
  localparam logic [2:0] OP_LD3 = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_RES = 3'b101;
  localparam logic [2:0] OP_DIS = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

endpackage

// File: rtl/div_program_executor_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational compare-subtract step of the restoring divider.
// Ports:
//   rem  (in,  DW) : running remainder
//   rb   (in,  DW) : divisor
//   ge   (out, 1)  : rem >= rb (unsigned)
//   diff (out, DW) : rem - rb (only meaningful when ge is set)
// -----------------------------------------------------------------------------
module div_step #(
  parameter int DW = 4
) (
  input  logic [DW-1:0] rem,
  input  logic [DW-1:0] rb,
  output logic          ge,
  output logic [DW-1:0] diff
);

  assign ge   = (rem >= rb);
  assign diff = rem - rb;

endmodule

// File: rtl/div_program_executor.sv
// -----------------------------------------------------------------------------
// div_program_executor
// Fetches and executes the CLR/LD1/LD2/LD3/DIV/RES/DIS program held in an
// external combinational instruction memory, dividing by repeated
// subtraction and presenting the quotient on the display register.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : level-sampled launch request, only honoured in IDLE
//   func, value  : instruction fetched at the current selector
//   selector     : registered program counter to instruction memory
//   quotient     : written by RES
//   remainder    : written by RES
//   display      : written by DIS (copies quotient)
//   busy         : high from the cycle after launch until HALT
//   done         : one-cycle pulse, high during the HALT cycle
//   div_by_zero  : sticky, set by DIV with RB=0, cleared by CLR or rst
//   dbg_state    : current FSM state (isa_pkg::state_t encoding)
// Handshake: start is a level request with no acknowledge; it is accepted on
// the first rising edge where the FSM is in IDLE and start=1, and busy rises
// in the following cycle. done marks completion and needs no response.
// -----------------------------------------------------------------------------
module div_program_executor #(
  parameter int DW      = isa_pkg::DW,
  parameter int PCW     = isa_pkg::PCW,
  parameter int LAST_PC = isa_pkg::LAST_PC
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2:0]     func,
  input  logic [DW-1:0]  value,
  output logic [PCW-1:0] selector,
  output logic [DW-1:0]  quotient,
  output logic [DW-1:0]  remainder,
  output logic [DW-1:0]  display,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic [1:0]     dbg_state
);

  import isa_pkg::state_t, isa_pkg::ST_IDLE, isa_pkg::ST_EXEC,
         isa_pkg::ST_DIVIDE, isa_pkg::ST_HALT;
  import isa_pkg::OP_CLR, isa_pkg::OP_LD1, isa_pkg::OP_LD2, isa_pkg::OP_LD3,
         isa_pkg::OP_DIV, isa_pkg::OP_RES, isa_pkg::OP_DIS;

  state_t        state;
  logic [DW-1:0] ra, rb, rq, rem;
  logic          ge;
  logic [DW-1:0] diff;
  logic          at_last;
  logic          rb_zero;
  logic          enter_divide;

  div_step #(.DW(DW)) u_div_step (
    .rem  (rem),
    .rb   (rb),
    .ge   (ge),
    .diff (diff)
  );

  assign at_last      = (selector == PCW'(LAST_PC));
  assign rb_zero      = (rb == '0);
  // A DIV with a non-zero divisor parks the selector and hands over to DIVIDE;
  // every other instruction advances (or halts) this cycle.
  assign enter_divide = (func == OP_DIV) && !rb_zero;
  assign dbg_state    = 2'(state);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      selector    <= '0;
      quotient    <= '0;
      remainder   <= '0;
      display     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      ra          <= '0;
      rb          <= '0;
      rq          <= '0;
      rem         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          selector <= '0;
          if (start) begin
            state <= ST_EXEC;
            busy  <= 1'b1;
          end
        end

        ST_EXEC: begin
          case (func)
            OP_CLR: begin
              ra          <= '0;
              rb          <= '0;
              rq          <= '0;
              rem         <= '0;
              quotient    <= '0;
              remainder   <= '0;
              div_by_zero <= 1'b0;
            end
            OP_LD1: ra <= value;
            OP_LD2: rb <= value;
            OP_LD3: rq <= value;
            OP_DIV: begin
              rem <= ra;
              if (rb_zero) begin
                div_by_zero <= 1'b1;
                rq          <= '1;
              end
            end
            OP_RES: begin
              quotient  <= rq;
              remainder <= rem;
            end
            OP_DIS: display <= quotient;
            default: ;
          endcase

          // Halting on the last address keeps selector from ever reaching 7.
          if ((func == OP_DIS) || (at_last && !enter_divide)) begin
            state    <= ST_HALT;
            done     <= 1'b1;
            busy     <= 1'b0;
            selector <= '0;
          end else if (enter_divide) begin
            state <= ST_DIVIDE;
          end else begin
            selector <= selector + 1'b1;
          end
        end

        ST_DIVIDE: begin
          if (ge) begin
            rem <= diff;
            rq  <= rq + 1'b1;
          end else if (at_last) begin
            state    <= ST_HALT;
            done     <= 1'b1;
            busy     <= 1'b0;
            selector <= '0;
          end else begin
            selector <= selector + 1'b1;
            state    <= ST_EXEC;
          end
        end

        ST_HALT: begin
          selector <= '0;
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
